// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the bridge state encoding.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_DATA,
    ST_WR_CHK,
    ST_RD_REQ,
    ST_RD_CHK,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_regfile_bridge.sv
// AHB-Lite slave front-end driving Wren/Rden strobes into a register file and
// returning HRDATA/HREADYOUT/HRESP, including wait states and two-cycle ERROR.
module ahb_regfile_bridge
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned HADDR_W = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               HSEL,
  input  logic [HADDR_W-1:0] HADDR,
  input  logic               HWRITE,
  input  logic [1:0]         HTRANS,
  input  logic [DATA_W-1:0]  HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [DATA_W-1:0]  HRDATA,
  output logic               Wren,
  output logic               Rden,
  output logic [DATA_W-1:0]  WrData,
  output logic [DEPTH-1:0]   Adresse,
  input  logic [DATA_W-1:0]  RdData,
  input  logic               RdData_Valid,
  input  logic               ReadyToWork
);

  localparam int unsigned        CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [DEPTH-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;

  logic                accept;
  logic                out_of_range;
  logic                complete;
  logic                hready;
  hresp_e              hresp;
  state_e              accept_state;

  // Address-phase decode, shared by every cycle in which the slave is ready.
  always_comb begin
    accept       = HSEL && HREADY &&
                   ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    out_of_range = |HADDR[HADDR_W-1:DEPTH];
    accept_state = ST_IDLE;
    if (accept) begin
      if (out_of_range)  accept_state = ST_ERR1;
      else if (HWRITE)   accept_state = ST_WR_DATA;
      else               accept_state = ST_RD_REQ;
    end
  end

  // Next-state and bus-response logic; read completion is routed through IDLE.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    hrdata_d = hrdata_q;
    hready   = 1'b1;
    hresp    = HRESP_OKAY;
    complete = 1'b0;

    case (state_q)
      ST_IDLE: begin
        complete = 1'b1;
      end
      ST_WR_DATA: begin
        hready  = 1'b0;
        state_d = ST_WR_CHK;
      end
      ST_WR_CHK: begin
        if (ReadyToWork) begin
          complete = 1'b1;
        end else begin
          hready  = 1'b0;
          state_d = ST_ERR1;
        end
      end
      ST_RD_REQ: begin
        hready  = 1'b0;
        cnt_d   = '0;
        state_d = ST_RD_CHK;
      end
      ST_RD_CHK: begin
        hready = 1'b0;
        if (RdData_Valid) begin
          hrdata_d = RdData;
          state_d  = ST_IDLE;
        end else if (!ReadyToWork) begin
          state_d = ST_ERR1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_ERR1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hresp    = HRESP_ERROR;
        complete = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any ready cycle doubles as the address phase of the next transfer.
    if (complete) begin
      state_d = accept_state;
      if (accept) addr_d = HADDR[DEPTH-1:0];
    end
  end

  // State, address, timeout counter and read-data registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      hrdata_q <= hrdata_d;
    end
  end

  // Output decode: strobes come only from the state register.
  always_comb begin
    HREADYOUT = hready;
    HRESP     = hresp;
    HRDATA    = hrdata_q;
    Wren      = (state_q == ST_WR_DATA);
    Rden      = (state_q == ST_RD_REQ);
    WrData    = HWDATA;
    Adresse   = addr_q;
  end

endmodule

// File: tb/tb_ahb_regfile_bridge.sv
// Scoreboard bench for ahb_regfile_bridge with a behavioural register file.
module tb_ahb_regfile_bridge;
  import ahb_pkg::*;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned HADDR_W = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [3:0]  REJ_ADDR   = 4'hE;   // register file rejects writes here
  localparam logic [3:0]  NOANS_ADDR = 4'hF;   // register file never answers reads here

  logic              CLK = 1'b0;
  logic              RST;
  logic              HSEL;
  logic [31:0]       HADDR;
  logic              HWRITE;
  logic [1:0]        HTRANS;
  logic [7:0]        HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [7:0]        HRDATA;
  logic              Wren;
  logic              Rden;
  logic [7:0]        WrData;
  logic [3:0]        Adresse;
  logic [7:0]        RdData;
  logic              RdData_Valid;
  logic              ReadyToWork;

  always #5 CLK = ~CLK;
  assign HREADY = HREADYOUT;

  ahb_regfile_bridge #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .HADDR_W(HADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HWRITE      (HWRITE),
    .HTRANS      (HTRANS),
    .HWDATA      (HWDATA),
    .HREADY      (HREADY),
    .HREADYOUT   (HREADYOUT),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .Wren        (Wren),
    .Rden        (Rden),
    .WrData      (WrData),
    .Adresse     (Adresse),
    .RdData      (RdData),
    .RdData_Valid(RdData_Valid),
    .ReadyToWork (ReadyToWork)
  );

  // Register file: data one cycle after Rden, ReadyToWork reflects last write.
  logic [7:0] rf_mem [16];
  always @(posedge CLK) begin
    if (RST) begin
      RdData_Valid <= 1'b0;
      RdData       <= '0;
      ReadyToWork  <= 1'b1;
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
    end else begin
      RdData_Valid <= Rden && (Adresse != NOANS_ADDR);
      if (Rden) RdData <= rf_mem[Adresse];
      ReadyToWork <= !(Wren && (Adresse == REJ_ADDR));
      if (Wren && (Adresse != REJ_ADDR)) rf_mem[Adresse] <= WrData;
    end
  end

  typedef struct {
    int         id;
    int         waits;
    logic       err;
    logic [7:0] hrdata;
    int         wren;
    int         rden;
    logic [3:0] addr;
    logic [7:0] wdata;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ref_mem [16];
  logic [7:0] ref_hrdata;
  int         txn_id;

  int n_cmp = 0;
  int n_err = 0;

  int         dp_waits, dp_wren, dp_rden;
  logic       dp_valid, dp_last_hresp;
  logic [7:0] dp_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model of one transfer's data-phase outcome.
  task automatic expect_txn(input bit hsel, input bit [1:0] trans, input bit wr,
                            input bit [31:0] addr, input bit [7:0] wd);
    exp_t e;
    bit   oor;
    bit [3:0] a;
    a   = addr[3:0];
    oor = (addr[31:4] != 0);
    e.id = txn_id; e.waits = 0; e.err = 1'b0; e.wren = 0; e.rden = 0;
    e.addr = a; e.wdata = wd;
    txn_id++;
    if (!hsel || !trans[1]) begin
      e.waits = 0;
    end else if (oor) begin
      e.waits = 1; e.err = 1'b1;
    end else if (wr) begin
      e.wren = 1;
      if (a == REJ_ADDR) begin
        e.waits = 3; e.err = 1'b1;
      end else begin
        e.waits = 1;
        ref_mem[a] = wd;
      end
    end else begin
      e.rden = 1;
      if (a == NOANS_ADDR) begin
        e.waits = TIMEOUT + 3; e.err = 1'b1;
      end else begin
        e.waits = 2;
        ref_hrdata = ref_mem[a];
      end
    end
    e.hrdata = ref_hrdata;
    sb.push_back(e);
  endtask

  task automatic finish_dp();
    exp_t e;
    e = sb.pop_front();
    check($sformatf("t%0d.waits", e.id),  dp_waits, e.waits);
    check($sformatf("t%0d.hresp", e.id),  HRESP,    e.err);
    check($sformatf("t%0d.hrdata", e.id), HRDATA,   e.hrdata);
    check($sformatf("t%0d.wren", e.id),   dp_wren,  e.wren);
    check($sformatf("t%0d.rden", e.id),   dp_rden,  e.rden);
    if (e.err) check($sformatf("t%0d.err1_hresp", e.id), dp_last_hresp, 1);
  endtask

  // Drive one address phase while monitoring the outstanding data phase.
  task automatic step(input bit hsel, input bit [1:0] trans, input bit wr,
                      input bit [31:0] addr, input bit [7:0] wd);
    int guard;
    bit rdy;
    HSEL = hsel; HTRANS = trans; HWRITE = wr; HADDR = addr; HWDATA = dp_wdata;
    expect_txn(hsel, trans, wr, addr, wd);
    guard = 0;
    do begin
      @(negedge CLK);
      rdy = HREADYOUT;
      if (dp_valid) begin
        check("strobe_excl", {31'b0, Wren & Rden}, 0);
        if (Wren) begin
          dp_wren++;
          check($sformatf("t%0d.wr_addr", sb[0].id), Adresse, sb[0].addr);
          check($sformatf("t%0d.wr_data", sb[0].id), WrData,  sb[0].wdata);
        end
        if (Rden) begin
          dp_rden++;
          check($sformatf("t%0d.rd_addr", sb[0].id), Adresse, sb[0].addr);
        end
        if (rdy) finish_dp();
        else begin
          dp_waits++;
          dp_last_hresp = HRESP;
        end
      end
      @(posedge CLK);
      #1;
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL hready_timeout: got HREADYOUT=0 for %0d cycles expected completion", guard);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
    dp_valid = 1'b1; dp_waits = 0; dp_wren = 0; dp_rden = 0; dp_last_hresp = 1'b0;
    dp_wdata = wd;
  endtask

  initial begin
    bit [3:0] a;
    bit [7:0] d;
    RST = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_hrdata = '0; txn_id = 0;
    dp_valid = 1'b0; dp_waits = 0; dp_wren = 0; dp_rden = 0; dp_last_hresp = 1'b0; dp_wdata = '0;

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst.hreadyout", HREADYOUT, 1);
    check("rst.hresp",     HRESP,     0);
    check("rst.hrdata",    HRDATA,    0);
    check("rst.wren",      Wren,      0);
    check("rst.rden",      Rden,      0);
    @(posedge CLK); #1;

    step(1, HTRANS_NONSEQ, 1, 32'h5,   8'hA5);   // write
    step(1, HTRANS_NONSEQ, 0, 32'h5,   8'h00);   // read back
    step(1, HTRANS_NONSEQ, 1, {28'h0, REJ_ADDR}, 8'h77);  // rejected write
    step(1, HTRANS_NONSEQ, 0, 32'h10,  8'h00);   // out of range
    step(1, HTRANS_NONSEQ, 0, {28'h0, NOANS_ADDR}, 8'h00); // timeout
    step(1, HTRANS_NONSEQ, 1, 32'h3,   8'h11);   // back-to-back write/read
    step(1, HTRANS_SEQ,    0, 32'h3,   8'h00);
    step(1, HTRANS_BUSY,   0, 32'h3,   8'h00);
    step(1, HTRANS_IDLE,   1, 32'h5,   8'h00);
    step(0, HTRANS_NONSEQ, 1, 32'h5,   8'hFF);   // not selected
    step(1, HTRANS_NONSEQ, 1, 32'h100, 8'h5A);   // out-of-range write
    step(1, HTRANS_NONSEQ, 0, 32'h5,   8'h00);
    for (int i = 0; i < 6; i++) begin
      a = 4'($urandom_range(0, 13));
      d = 8'($urandom_range(0, 255));
      step(1, HTRANS_NONSEQ, 1, {28'h0, a}, d);
      step(1, HTRANS_SEQ,    0, {28'h0, a}, 8'h00);
    end
    step(1, HTRANS_NONSEQ, 0, 32'h3, 8'h00);
    step(1, HTRANS_IDLE,   0, 32'h0, 8'h00);
    step(1, HTRANS_IDLE,   0, 32'h0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
